// File: rtl/adc_pkg.sv
// Shared definitions for the ADS1115 channel scanner.
//   - I2C instruction codes understood by the byte-level I2C master
//   - ADS1115 register pointer values
//   - config-word field positions and a helper that assembles the word
//   - top-level state enumeration
//   - round-robin channel picker
package adc_pkg;

  localparam logic [1:0] I2C_START = 2'd0;
  localparam logic [1:0] I2C_STOP  = 2'd1;
  localparam logic [1:0] I2C_READ  = 2'd2;
  localparam logic [1:0] I2C_WRITE = 2'd3;

  localparam logic [7:0] REG_CONVERSION = 8'h00;
  localparam logic [7:0] REG_CONFIG     = 8'h01;

  // Bit positions inside the 16-bit config register.
  localparam int CFG_OS_BIT   = 15;
  localparam int CFG_MUX_LSB  = 12;
  localparam int CFG_PGA_LSB  = 9;
  localparam int CFG_MODE_BIT = 8;
  localparam int CFG_DR_LSB   = 5;
  localparam logic [4:0] CFG_COMP_DEFAULT = 5'b00011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_POLL,
    ST_POINT,
    ST_READ,
    ST_OUTPUT,
    ST_NEXT
  } state_e;

  // Single-shot conversion of AINch against GND (MUX = 1,ch).
  function automatic logic [15:0] config_word(input logic [1:0] ch,
                                              input logic [2:0] pga,
                                              input logic [2:0] dr);
    logic [15:0] w;
    w = '0;
    w[CFG_OS_BIT]          = 1'b1;
    w[CFG_MUX_LSB +: 3]    = {1'b1, ch};
    w[CFG_PGA_LSB +: 3]    = pga;
    w[CFG_MODE_BIT]        = 1'b1;
    w[CFG_DR_LSB +: 3]     = dr;
    w[4:0]                 = CFG_COMP_DEFAULT;
    return w;
  endfunction

  // Lowest set mask bit at or after ptr, wrapping at n. Scanning offsets
  // from high to low lets the smallest offset win.
  function automatic logic [1:0] pick_channel(input logic [3:0] mask,
                                              input logic [1:0] ptr,
                                              input int         n);
    logic [1:0] sel;
    int         idx;
    sel = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (mask[idx[1:0]]) sel = idx[1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/i2c_step.sv
// One I2C instruction handshake towards the byte-level I2C master.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_i                    request to issue instr_i/byte_i (sampled when idle)
//   instr_i, byte_i          instruction and write byte to issue
//   i2c_complete_i           master completion flag
//   i2c_enable_o             instruction request to the master
//   i2c_instruction_o        latched instruction
//   i2c_byte_to_send_o       latched write byte
//   done_o                   one-cycle pulse: instruction finished
module i2c_step (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [1:0] instr_i,
  input  logic [7:0] byte_i,
  input  logic       i2c_complete_i,
  output logic       i2c_enable_o,
  output logic [1:0] i2c_instruction_o,
  output logic [7:0] i2c_byte_to_send_o,
  output logic       done_o
);

  logic       en_q;
  logic       seen_low_q;
  logic [1:0] instr_q;
  logic [7:0] byte_q;

  // Completion only counts once the master has been seen low after issue,
  // so a stale high from the previous instruction is ignored.
  assign done_o = en_q & seen_low_q & i2c_complete_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      seen_low_q <= 1'b0;
      instr_q    <= 2'd0;
      byte_q     <= 8'd0;
    end else if (!en_q) begin
      if (req_i) begin
        en_q       <= 1'b1;
        seen_low_q <= 1'b0;
        instr_q    <= instr_i;
        byte_q     <= byte_i;
      end
    end else if (done_o) begin
      en_q       <= 1'b0;
      seen_low_q <= 1'b0;
    end else if (!i2c_complete_i) begin
      seen_low_q <= 1'b1;
    end
  end

  assign i2c_enable_o       = en_q;
  assign i2c_instruction_o  = instr_q;
  assign i2c_byte_to_send_o = byte_q;

endmodule

// File: rtl/adc_scanner.sv
// Round-robin scanner for an ADS1115 over a byte-level I2C master.
//
//   state  | meaning
//   IDLE   | waiting for enable_i and a non-zero effective mask
//   CONFIG | write config register: start single-shot on channel ch
//   POLL   | read config register until OS=1 or poll limit reached
//   POINT  | set register pointer to the conversion register
//   READ   | read 16-bit conversion result
//   OUTPUT | present sample until sample_ready_i
//   NEXT   | advance round-robin pointer, pick next channel or idle
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   enable_i, channel_mask_i         scan control
//   sample_o, channel_o,
//   sample_valid_o, sample_ready_i   result handshake
//   timeout_o                        pulse on poll-limit expiry
//   busy_o                           not IDLE
//   i2c_*                            I2C master instruction interface
module adc_scanner
  import adc_pkg::*;
#(
  parameter logic [6:0]  ADDRESS      = 7'h48,
  parameter int          NUM_CHANNELS = 4,
  parameter logic [2:0]  PGA          = 3'b001,
  parameter logic [2:0]  DATA_RATE    = 3'b111,
  parameter logic [15:0] POLL_LIMIT   = 16'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [3:0]  channel_mask_i,
  output logic [15:0] sample_o,
  output logic [1:0]  channel_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        timeout_o,
  output logic        busy_o,
  output logic [1:0]  i2c_instruction_o,
  output logic        i2c_enable_o,
  output logic [7:0]  i2c_byte_to_send_o,
  input  logic [7:0]  i2c_byte_received_i,
  input  logic        i2c_complete_i
);

  localparam logic [3:0] CH_FIELD = 4'((1 << NUM_CHANNELS) - 1);
  localparam logic [7:0] ADDR_W   = {ADDRESS, 1'b0};
  localparam logic [7:0] ADDR_R   = {ADDRESS, 1'b1};

  state_e      state_q, state_d;
  logic [2:0]  sub_q, sub_d;
  logic [1:0]  ch_q, ch_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  rd_msb_q, rd_msb_d;
  logic [15:0] sample_q, sample_d;
  logic [1:0]  chan_out_q, chan_out_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic        step_req;
  logic [1:0]  step_instr;
  logic [7:0]  step_byte;
  logic        step_done;

  logic [3:0]  eff_mask;
  logic [1:0]  ptr_next;
  logic [15:0] cfg;

  assign eff_mask = channel_mask_i & CH_FIELD;
  assign ptr_next = 2'((int'(ch_q) + 1) % NUM_CHANNELS);
  assign cfg      = config_word(ch_q, PGA, DATA_RATE);

  i2c_step u_step (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_i              (step_req),
    .instr_i            (step_instr),
    .byte_i             (step_byte),
    .i2c_complete_i     (i2c_complete_i),
    .i2c_enable_o       (i2c_enable_o),
    .i2c_instruction_o  (i2c_instruction_o),
    .i2c_byte_to_send_o (i2c_byte_to_send_o),
    .done_o             (step_done)
  );

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    ch_d       = ch_q;
    ptr_d      = ptr_q;
    poll_cnt_d = poll_cnt_q;
    rd_msb_d   = rd_msb_q;
    sample_d   = sample_q;
    chan_out_d = chan_out_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    step_req   = 1'b0;
    step_instr = I2C_START;
    step_byte  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (enable_i && (eff_mask != 4'd0)) begin
          state_d = ST_CONFIG;
          sub_d   = 3'd0;
          ch_d    = pick_channel(eff_mask, ptr_q, NUM_CHANNELS);
        end
      end

      ST_CONFIG: begin
        step_req = 1'b1;
        case (sub_q)
          3'd0:    step_instr = I2C_START;
          3'd1:    begin step_instr = I2C_WRITE; step_byte = ADDR_W;     end
          3'd2:    begin step_instr = I2C_WRITE; step_byte = REG_CONFIG; end
          3'd3:    begin step_instr = I2C_WRITE; step_byte = cfg[15:8];  end
          3'd4:    begin step_instr = I2C_WRITE; step_byte = cfg[7:0];   end
          default: step_instr = I2C_STOP;
        endcase
        if (step_done) begin
          if (sub_q == 3'd5) begin
            sub_d      = 3'd0;
            poll_cnt_d = 16'd0;
            state_d    = ST_POLL;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
      end

      ST_POLL, ST_READ: begin
        step_req = 1'b1;
        case (sub_q)
          3'd0:    step_instr = I2C_START;
          3'd1:    begin step_instr = I2C_WRITE; step_byte = ADDR_R; end
          3'd2:    step_instr = I2C_READ;
          3'd3:    step_instr = I2C_READ;
          default: step_instr = I2C_STOP;
        endcase
        if (step_done) begin
          if (sub_q == 3'd2) rd_msb_d = i2c_byte_received_i;
          if (state_q == ST_READ && sub_q == 3'd3) begin
            sample_d   = {rd_msb_q, i2c_byte_received_i};
            chan_out_d = ch_q;
          end
          if (sub_q == 3'd4) begin
            sub_d = 3'd0;
            if (state_q == ST_READ) begin
              valid_d = 1'b1;
              state_d = ST_OUTPUT;
            end else if (rd_msb_q[CFG_OS_BIT-8]) begin
              poll_cnt_d = 16'd0;
              state_d    = ST_POINT;
            end else if ((poll_cnt_q + 16'd1) >= POLL_LIMIT) begin
              // Conversion never finished: drop this channel.
              poll_cnt_d = 16'd0;
              timeout_d  = 1'b1;
              state_d    = ST_NEXT;
            end else begin
              poll_cnt_d = poll_cnt_q + 16'd1;
            end
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
      end

      ST_POINT: begin
        step_req = 1'b1;
        case (sub_q)
          3'd0:    step_instr = I2C_START;
          3'd1:    begin step_instr = I2C_WRITE; step_byte = ADDR_W;         end
          3'd2:    begin step_instr = I2C_WRITE; step_byte = REG_CONVERSION; end
          default: step_instr = I2C_STOP;
        endcase
        if (step_done) begin
          if (sub_q == 3'd3) begin
            sub_d   = 3'd0;
            state_d = ST_READ;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
      end

      ST_OUTPUT: begin
        if (sample_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        ptr_d = ptr_next;
        sub_d = 3'd0;
        if (enable_i && (eff_mask != 4'd0)) begin
          state_d = ST_CONFIG;
          ch_d    = pick_channel(eff_mask, ptr_next, NUM_CHANNELS);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sub_q      <= 3'd0;
      ch_q       <= 2'd0;
      ptr_q      <= 2'd0;
      poll_cnt_q <= 16'd0;
      rd_msb_q   <= 8'd0;
      sample_q   <= 16'd0;
      chan_out_q <= 2'd0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
      poll_cnt_q <= poll_cnt_d;
      rd_msb_q   <= rd_msb_d;
      sample_q   <= sample_d;
      chan_out_q <= chan_out_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign sample_o       = sample_q;
  assign channel_o      = chan_out_q;
  assign sample_valid_o = valid_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_scanner.sv
module tb_adc_scanner;
  import adc_pkg::*;

  localparam logic [6:0] ADDR = 7'h48;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  mask = 4'd0;
  logic        sample_ready = 1'b0;
  logic        i2c_complete = 1'b0;
  logic [7:0]  i2c_rx = 8'd0;

  logic [15:0] sample_o;
  logic [1:0]  channel_o;
  logic        sample_valid_o;
  logic        timeout_o;
  logic        busy_o;
  logic [1:0]  i2c_instruction_o;
  logic        i2c_enable_o;
  logic [7:0]  i2c_byte_to_send_o;

  adc_scanner #(.POLL_LIMIT(16'd4)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .channel_mask_i     (mask),
    .sample_o           (sample_o),
    .channel_o          (channel_o),
    .sample_valid_o     (sample_valid_o),
    .sample_ready_i     (sample_ready),
    .timeout_o          (timeout_o),
    .busy_o             (busy_o),
    .i2c_instruction_o  (i2c_instruction_o),
    .i2c_enable_o       (i2c_enable_o),
    .i2c_byte_to_send_o (i2c_byte_to_send_o),
    .i2c_byte_received_i(i2c_rx),
    .i2c_complete_i     (i2c_complete)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] cfg_seen[$];

  // ADS1115 + I2C master model
  int          cnt = 0;
  int          xfers = 0;
  int          polls = 0;
  int          to_pulses = 0;
  int          to_cycles = 0;
  logic        to_prev = 1'b0;
  logic [7:0]  reg_ptr = 8'h00;
  logic [7:0]  wb[4];
  int          wcount = 0;
  int          rd_idx = 0;
  int          os_zero_polls = 0;
  int          os_left = 0;
  int          stuck_ch = -1;
  logic [15:0] conv = 16'h0000;

  always @(negedge clk) begin
    if (timeout_o) to_cycles++;
    if (timeout_o && !to_prev) to_pulses++;
    to_prev = timeout_o;
    if (rst || !i2c_enable_o) begin
      i2c_complete = 1'b0;
      cnt = 0;
    end else if (!i2c_complete) begin
      cnt++;
      if (cnt >= 2) begin
        i2c_complete = 1'b1;
        xfers++;
        case (i2c_instruction_o)
          I2C_START: begin wcount = 0; rd_idx = 0; end
          I2C_WRITE: begin
            if (wcount < 4) wb[wcount] = i2c_byte_to_send_o;
            wcount++;
          end
          I2C_READ: begin
            if (reg_ptr == REG_CONFIG) begin
              if (rd_idx == 0) begin
                polls++;
                if (os_left > 0) begin i2c_rx = 8'h03; os_left--; end
                else i2c_rx = 8'h83;
              end else i2c_rx = 8'h83;
            end else begin
              i2c_rx = (rd_idx == 0) ? conv[15:8] : conv[7:0];
            end
            rd_idx++;
          end
          default: begin
            if (wcount >= 2 && wb[0] == {ADDR, 1'b0}) begin
              reg_ptr = wb[1];
              if (wcount == 4 && wb[1] == REG_CONFIG) begin
                cfg_seen.push_back(wb[2]);
                os_left = (int'(wb[2][5:4]) == stuck_ch) ? 1000 : os_zero_polls;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sample(input int hold);
    int   n;
    int   x0;
    exp_t e;
    n = 0;
    while (!sample_valid_o && n < 3000) begin @(negedge clk); n++; end
    check("sample_valid_seen", 32'(sample_valid_o), 1);
    if (sample_valid_o) begin
      check("scoreboard_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sample_channel", 32'(channel_o), 32'(e.ch));
        check("sample_data", 32'(sample_o), 32'(e.data));
        x0 = xfers;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("hold_valid", 32'(sample_valid_o), 1);
          check("hold_data", 32'(sample_o), 32'(e.data));
          check("hold_channel", 32'(channel_o), 32'(e.ch));
        end
        if (hold > 0) check("hold_no_i2c", xfers, x0);
      end
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
      check("valid_drop", 32'(sample_valid_o), 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 3000) begin @(negedge clk); n++; end
    check("idle_reached", 32'(busy_o), 0);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy_o && n < 100) begin @(negedge clk); n++; end
    check("busy_reached", 32'(busy_o), 1);
  endtask

  task automatic wait_cfg(input int k);
    int n;
    n = 0;
    while (cfg_seen.size() < k && n < 3000) begin @(negedge clk); n++; end
    check("cfg_count", cfg_seen.size(), k);
  endtask

  task automatic check_cfg(input string tag, input logic [7:0] exp);
    if (cfg_seen.size() > 0) check(tag, 32'(cfg_seen.pop_front()), 32'(exp));
    else check(tag, 'x, 32'(exp));
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_sample"},  32'(sample_o), 0);
    check({pfx, "_channel"}, 32'(channel_o), 0);
    check({pfx, "_valid"},   32'(sample_valid_o), 0);
    check({pfx, "_timeout"}, 32'(timeout_o), 0);
    check({pfx, "_busy"},    32'(busy_o), 0);
    check({pfx, "_i2c_en"},  32'(i2c_enable_o), 0);
    check({pfx, "_i2c_ins"}, 32'(i2c_instruction_o), 0);
    check({pfx, "_i2c_byte"},32'(i2c_byte_to_send_o), 0);
  endtask

  initial begin
    int   n;
    logic found;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Zero mask keeps the block idle
    enable = 1'b1;
    mask   = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("zero_mask_busy", 32'(busy_o), 0);
    end

    // Two channels, OS=1 on the first poll
    os_zero_polls = 0;
    conv = 16'h1234;
    exp_q.push_back('{ch: 2'd0, data: 16'h1234});
    exp_q.push_back('{ch: 2'd2, data: 16'h1234});
    mask = 4'b0101;
    expect_sample(0);
    wait_cfg(2);
    enable = 1'b0;
    expect_sample(0);
    wait_idle();
    check_cfg("cfg_msb_ch0", 8'hC3);
    check_cfg("cfg_msb_ch2", 8'hE3);

    // Three OS=0 polls then OS=1; enable dropped during CONFIG
    os_zero_polls = 3;
    conv  = 16'h8001;
    polls = 0;
    to_pulses = 0;
    mask  = 4'b0010;
    exp_q.push_back('{ch: 2'd1, data: 16'h8001});
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    expect_sample(0);
    check("poll_count_4", polls, 4);
    check("no_timeout", to_pulses, 0);
    wait_idle();
    repeat (5) @(negedge clk);
    check("stays_idle", 32'(busy_o), 0);
    check_cfg("cfg_msb_ch1", 8'hD3);

    // Channel 3 never finishes: timeout, then channel 0 is scanned
    os_zero_polls = 0;
    stuck_ch = 3;
    conv  = 16'h7FFF;
    polls = 0;
    to_pulses = 0;
    to_cycles = 0;
    mask  = 4'b1001;
    exp_q.push_back('{ch: 2'd0, data: 16'h7FFF});
    enable = 1'b1;
    wait_cfg(2);
    enable = 1'b0;
    expect_sample(0);
    wait_idle();
    check("timeout_pulses", to_pulses, 1);
    check("timeout_width", to_cycles, 1);
    check("poll_count_5", polls, 5);
    check_cfg("cfg_msb_ch3", 8'hF3);
    check_cfg("cfg_msb_ch0b", 8'hC3);

    // Consumer stalls for 20 cycles
    stuck_ch = -1;
    conv = 16'hBEEF;
    mask = 4'b0100;
    exp_q.push_back('{ch: 2'd2, data: 16'hBEEF});
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    expect_sample(20);
    wait_idle();
    check_cfg("cfg_msb_ch2b", 8'hE3);

    // Reset during a conversion READ
    conv = 16'h0042;
    mask = 4'b1111;
    enable = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (i2c_enable_o && i2c_instruction_o == I2C_READ && reg_ptr == REG_CONVERSION)
        found = 1'b1;
    end
    check("reached_read", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    cfg_seen.delete();
    exp_q.push_back('{ch: 2'd0, data: 16'h0042});
    wait_cfg(1);
    enable = 1'b0;
    check_cfg("restart_ch0", 8'hC3);
    expect_sample(0);
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/adc_scanner.md
ADC_SCANNER -- requirements
Module: adc_scanner

Interface
REQ-001 Parameter ADDRESS, default 7'h48, 7-bit I2C address of the ADS1115.
REQ-002 Parameter NUM_CHANNELS, default 4, legal range 1..4, number of single-ended inputs AIN0..AIN(N-1) that can be scanned.
REQ-003 Parameter PGA, default 3'b001, PGA field written into every config word.
REQ-004 Parameter DATA_RATE, default 3'b111, DR field written into every config word.
REQ-005 Parameter POLL_LIMIT, default 16'd64, maximum number of OS-bit polls per conversion before a timeout.
REQ-006 Port clk_i, input, 1, the block's one clock; all logic is on its rising edge.
REQ-007 Port rst_i, input, 1, reset; synchronous and active-high.
REQ-008 Port enable_i, input, 1, 1 = scan continuously, 0 = stop after the current channel.
REQ-009 Port channel_mask_i, input, 4, per-channel scan enable; bits at or above NUM_CHANNELS are ignored.
REQ-010 Port sample_o, output, 16, conversion result (signed two's complement).
REQ-011 Port channel_o, output, 2, channel index of sample_o.
REQ-012 Port sample_valid_o, output, 1, sample_o and channel_o are valid.
REQ-013 Port sample_ready_i, input, 1, consumer accepts the sample.
REQ-014 Port timeout_o, output, 1, one-cycle pulse when a channel's poll limit is exceeded.
REQ-015 Port busy_o, output, 1, high in any state other than IDLE.
REQ-016 Port i2c_instruction_o, output, 2, I2C instruction: 0 START, 1 STOP, 2 READ, 3 WRITE.
REQ-017 Port i2c_enable_o, output, 1, I2C instruction request.
REQ-018 Port i2c_byte_to_send_o, output, 8, byte sent by a WRITE instruction.
REQ-019 Port i2c_byte_received_i, input, 8, byte returned by a READ instruction.
REQ-020 Port i2c_complete_i, input, 1, the I2C master has finished the current instruction.

Function
REQ-021 Top-level states SHALL be IDLE, CONFIG, POLL, POINT, READ, OUTPUT and NEXT; a sub-step counter sequences the I2C instructions within each state.
REQ-022 I2C handshake, applied to every instruction:
- set instruction and byte, assert i2c_enable_o;
- wait until i2c_complete_i has been seen low, then wait until it is seen high;
- deassert i2c_enable_o in the same cycle the high is seen, then advance one sub-step.
REQ-023 IDLE -> CONFIG when enable_i=1 and the effective mask is non-zero; the channel chosen is the lowest set mask bit at or after the round-robin pointer, wrapping from NUM_CHANNELS-1 to 0.
REQ-024 CONFIG: START, WRITE {ADDRESS,0}, WRITE 8'h01, WRITE MSB, WRITE LSB, STOP, where:
- MSB = {1'b1, 1'b1, ch[1:0], PGA, 1'b1} (single-shot mode);
- LSB = {DATA_RATE, 5'b00011}.
REQ-025 POLL: START, WRITE {ADDRESS,1}, READ MSB, READ LSB, STOP.
- MSB bit7 = 1: go to POINT.
- MSB bit7 = 0: increment the poll count and repeat POLL.
- Poll count reaches POLL_LIMIT: pulse timeout_o for one cycle, discard the channel, go to NEXT.
REQ-026 POINT: START, WRITE {ADDRESS,0}, WRITE 8'h00, STOP.
REQ-027 READ: START, WRITE {ADDRESS,1}, READ MSB, READ LSB, STOP; capture {MSB,LSB} into sample_o and the channel index into channel_o.
REQ-028 OUTPUT: hold sample_valid_o=1 with sample_o and channel_o stable until sample_ready_i=1; the transfer completes in that cycle, and sample_valid_o drops the following cycle.
REQ-029 NEXT: advance the round-robin pointer to ch+1 (mod NUM_CHANNELS).
- enable_i=1 and a mask bit is set: go to CONFIG for the next channel.
- Otherwise: go to IDLE.
REQ-030 channel_mask_i SHALL be sampled only at channel selection; mask changes mid-channel do not affect that channel.
REQ-031 enable_i falling mid-channel SHALL NOT abort; the channel completes, including OUTPUT, then the block returns to IDLE.
REQ-032 A mask of all zeros (effective) SHALL keep the block in IDLE with busy_o=0.
REQ-033 With NUM_CHANNELS=1, every scan SHALL use channel 0 and the pointer SHALL remain 0.

Reset
REQ-034 On rst_i=1 at a clock edge, the following SHALL take these values, overriding any in-flight transaction:
- state IDLE, round-robin pointer 0, poll count 0, sub-step 0;
- sample_o 0, channel_o 0, sample_valid_o 0, timeout_o 0, busy_o 0;
- i2c_enable_o 0, i2c_instruction_o 0, i2c_byte_to_send_o 0.

Structure
REQ-035 Shared package adc_pkg SHALL hold:
- the I2C instruction codes and register pointer constants;
- the config-word field positions;
- the state enumeration.
REQ-036 The REQ-022 handshake SHALL live in a sub-module i2c_step (inputs: request, instruction, byte; output: done pulse), instantiated once.

Verification
REQ-037 Mask 4'b0101, I2C model returns OS=1 on the first poll and conversion 16'h1234 -> two samples: channel 0 then channel 2, each 16'h1234; the config MSBs written are 8'hC3 and 8'hE3.
REQ-038 OS=0 for 3 polls, then 1 -> exactly 4 POLL transactions, then one sample; timeout_o stays 0.
REQ-039 OS always 0, POLL_LIMIT=4 -> one timeout_o pulse after the 4th poll, no sample for that channel, and the scan continues with the next channel.
REQ-040 sample_ready_i held low for 20 cycles -> sample_valid_o and the data stay stable for 20 cycles, and no new I2C traffic occurs during that time.
REQ-041 rst_i asserted mid-READ (i2c_enable_o=1) -> the next cycle shows all REQ-034 values; after release, the block restarts at channel 0.
REQ-042 enable_i dropped during CONFIG -> that channel completes and outputs its sample, then the block goes to IDLE and busy_o=0.
